// File: rtl/pixel_write_queue.sv
// Pixel write FIFO with a full-screen clear sweep, draining into the VGA adapter write port.
// Optional input clipping of off-screen pixels is enabled by defining PIXEL_CLIP_EN.
module pixel_write_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       plot_in,
    input  logic [7:0]                 x_in,
    input  logic [6:0]                 y_in,
    input  logic [2:0]                 colour_in,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clear_req,
    input  logic [2:0]                 clear_colour,
    output logic                       clear_busy,
    input  logic                       vga_ready,
    output logic                       vga_plot,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [2:0]                 vga_colour
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]  XLast = 8'(SCREEN_W - 1);
    localparam logic [6:0]  YLast = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {StRun, StWait, StClear} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic [2:0]      clr_col_q, clr_col_d;
    logic [7:0]      cx_q, cx_d;
    logic [6:0]      cy_q, cy_d;
    logic            plot_q, plot_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      col_q, col_d;

    logic [7:0]      mem_x [DEPTH];
    logic [6:0]      mem_y [DEPTH];
    logic [2:0]      mem_c [DEPTH];

    logic            in_range;
    logic            push;
    logic            pop;
    logic            sweep;
    logic            sweep_last;

`ifdef PIXEL_CLIP_EN
    assign in_range = (x_in <= XLast) && (y_in <= YLast);
`else
    assign in_range = 1'b1;
`endif

    assign full       = (count_q == CW'(DEPTH));
    assign push       = plot_in && in_range && !full;
    // The FIFO is frozen during a sweep so queued pixels land on top of the cleared screen.
    assign pop        = (state_q != StClear) && (count_q != '0) && vga_ready;
    assign sweep      = (state_q == StClear) && vga_ready;
    assign sweep_last = sweep && (cx_q == XLast) && (cy_q == YLast);

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        if (plot_in && in_range && full) begin
            overflow_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        plot_d = 1'b0;
        x_d    = x_q;
        y_d    = y_q;
        col_d  = col_q;

        if (pop) begin
            plot_d = 1'b1;
            x_d    = mem_x[rd_ptr_q];
            y_d    = mem_y[rd_ptr_q];
            col_d  = mem_c[rd_ptr_q];
        end else if (sweep) begin
            plot_d = 1'b1;
            x_d    = cx_q;
            y_d    = cy_q;
            col_d  = clr_col_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        clr_col_d = clr_col_q;
        cx_d      = cx_q;
        cy_d      = cy_q;

        unique case (state_q)
            StRun: begin
                // busy lingers one cycle after a sweep so a request in that cycle is ignored
                if (clear_req && !busy_q) begin
                    busy_d    = 1'b1;
                    clr_col_d = clear_colour;
                    state_d   = StWait;
                end else begin
                    busy_d = 1'b0;
                end
            end
            StWait: begin
                if ((count_q == '0) || ((count_q == CW'(1)) && pop && !push)) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (sweep_last) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = StRun;
                end else if (sweep) begin
                    if (cx_q == XLast) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StRun;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            clr_col_q  <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            plot_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            clr_col_q  <= clr_col_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            plot_q     <= plot_d;
            x_q        <= x_d;
            y_q        <= y_d;
            col_q      <= col_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_x[wr_ptr_q] <= x_in;
            mem_y[wr_ptr_q] <= y_in;
            mem_c[wr_ptr_q] <= colour_in;
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign clear_busy = busy_q;
    assign vga_plot   = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: queue-based reference model plus directed vectors.
module tb_pixel_write_queue;

    localparam int DEPTH = 8;
    localparam int W     = 160;
    localparam int H     = 120;

    logic        clock = 1'b0;
    logic        resetn;
    logic        plot_in;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic        clear_busy;
    logic        vga_ready;
    logic        vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    pixel_write_queue #(
        .DEPTH    (DEPTH),
        .SCREEN_W (W),
        .SCREEN_H (H)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .plot_in      (plot_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .colour_in    (colour_in),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .vga_ready    (vga_ready),
        .vga_plot     (vga_plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int n_plots = 0;
    bit chk_en = 1'b0;

    // Reference model: FIFO as a queue, sweep as a linear pixel index.
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       mq[$];
    pix_t       me;
    bit         m_ovf, m_busy, m_plot;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_col, m_ccol;
    int         m_mode;  // 0 drain, 1 waiting for empty, 2 sweeping
    int         m_idx;
    int         m_cnt;
    bit         m_valid, m_push;

    always @(posedge clock) begin
        if (!resetn) begin
            mq.delete();
            m_ovf = 0; m_busy = 0; m_plot = 0;
            m_x = '0; m_y = '0; m_col = '0; m_ccol = '0;
            m_mode = 0; m_idx = 0;
        end else begin
            m_cnt   = mq.size();
            m_valid = 1'b1;
`ifdef PIXEL_CLIP_EN
            m_valid = (int'(x_in) < W) && (int'(y_in) < H);
`endif
            m_push = plot_in && m_valid && (m_cnt < DEPTH);
            if (plot_in && m_valid && m_cnt == DEPTH) m_ovf = 1'b1;
            m_plot = 1'b0;
            if (m_mode != 2 && m_cnt > 0 && vga_ready) begin
                me = mq.pop_front();
                m_plot = 1'b1; m_x = me.x; m_y = me.y; m_col = me.c;
            end else if (m_mode == 2 && vga_ready) begin
                m_plot = 1'b1;
                m_x = 8'(m_idx % W); m_y = 7'(m_idx / W); m_col = m_ccol;
                m_idx++;
            end
            if (m_push) mq.push_back({x_in, y_in, colour_in});
            case (m_mode)
                0: if (clear_req && !m_busy) begin
                       m_mode = 1; m_busy = 1'b1; m_ccol = clear_colour;
                   end else m_busy = 1'b0;
                1: if (m_cnt == 0 || mq.size() == 0) m_mode = 2;
                default: if (m_idx == W * H) begin m_mode = 0; m_idx = 0; end
            endcase
        end
    end

    always @(negedge clock) begin
        if (vga_plot === 1'b1) n_plots++;
        if (chk_en) begin
            checks++;
            if ({count, full, overflow, clear_busy, vga_plot, vga_x, vga_y, vga_colour} !==
                {4'(mq.size()), (mq.size() == DEPTH), m_ovf, m_busy, m_plot, m_x, m_y, m_col}) begin
                errors++;
                $display("FAIL outputs t=%0t: got cnt=%0d full=%0b ovf=%0b busy=%0b plot=%0b xy=(%0d,%0d) c=%0d; exp cnt=%0d full=%0b ovf=%0b busy=%0b plot=%0b xy=(%0d,%0d) c=%0d",
                         $time, count, full, overflow, clear_busy, vga_plot, vga_x, vga_y, vga_colour,
                         mq.size(), (mq.size() == DEPTH), m_ovf, m_busy, m_plot, m_x, m_y, m_col);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; plot_in = 1'b0; clear_req = 1'b0; vga_ready = 1'b0;
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic push_one(input int x, input int y, input int c);
        plot_in = 1'b1; x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
        tick();
        plot_in = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input bit toggle);
        int k;
        k = 0;
        while (clear_busy && k < limit) begin
            if (toggle) vga_ready = ~vga_ready;
            tick(); k++;
        end
        if (clear_busy) check("busy_timeout", 1, 0);
    endtask

    int n0, k, first;

    initial begin
        resetn = 1'b0; plot_in = 1'b0; x_in = '0; y_in = '0; colour_in = '0;
        clear_req = 1'b0; clear_colour = '0; vga_ready = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_plot", vga_plot, 0);

        // Single pixel, two-edge latency
        vga_ready = 1'b1;
        plot_in = 1'b1; x_in = 8'd5; y_in = 7'd7; colour_in = 3'b001;
        tick();
        plot_in = 1'b0;
        tick();
        check("lat_plot", vga_plot, 1);
        check("lat_x", vga_x, 5);
        check("lat_y", vga_y, 7);
        check("lat_colour", vga_colour, 1);
        check("lat_count", count, 0);

        // Overfill with sink stalled, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) push_one(i, i + 20, i);
        check("fill_count", count, 8);
        check("fill_full", full, 1);
        check("fill_overflow", overflow, 1);
        n0 = n_plots;
        vga_ready = 1'b1;
        repeat (12) tick();
        check("drain_plots", n_plots - n0, 8);
        check("drain_last_x", vga_x, 7);
        check("drain_last_y", vga_y, 27);

        // Push while full with a simultaneous pop is still dropped
        do_reset();
        for (int i = 0; i < 8; i++) push_one(i, 1, 2);
        plot_in = 1'b1; x_in = 8'd99; vga_ready = 1'b1;
        tick();
        plot_in = 1'b0; vga_ready = 1'b0;
        check("pushpop_count", count, 7);
        check("pushpop_overflow", overflow, 1);
        check("pushpop_head_x", vga_x, 0);

        // Clear behind three queued pixels, with a push mid-sweep
        do_reset();
        push_one(10, 3, 6); push_one(11, 3, 6); push_one(12, 3, 6);
        vga_ready = 1'b1; clear_req = 1'b1; clear_colour = 3'b000;
        n0 = n_plots;
        tick();
        clear_req = 1'b0;
        check("clr_busy_set", clear_busy, 1);
        repeat (500) tick();
        push_one(50, 60, 7);
        wait_idle(25000, 1'b0);
        tick(); tick();
        check("clr_total_plots", n_plots - n0, 3 + W * H + 1);
        check("clr_after_x", vga_x, 50);
        check("clr_after_y", vga_y, 60);
        check("clr_after_colour", vga_colour, 7);

        // Sweep with the sink ready every other cycle
        do_reset();
        vga_ready = 1'b1; clear_req = 1'b1; clear_colour = 3'd5;
        n0 = n_plots;
        tick();
        clear_req = 1'b0;
        wait_idle(45000, 1'b1);
        tick(); tick();
        check("toggle_plots", n_plots - n0, W * H);

        // Clear timing with the sink always ready
        do_reset();
        vga_ready = 1'b1; clear_req = 1'b1; clear_colour = 3'd2;
        tick();
        clear_req = 1'b0;
        k = 1; first = 0;
        while (clear_busy && k < 25000) begin
            if (vga_plot && first == 0) first = k;
            tick(); k++;
        end
        check("timing_first_plot", first, 3);
        check("timing_busy_low", k, W * H + 3);

        // Reset mid-sweep aborts everything
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push_one(1, 1, 1);
        repeat (50) tick();
        check("abort_busy_before", clear_busy, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("abort_busy", clear_busy, 0);
        check("abort_count", count, 0);
        check("abort_plot", vga_plot, 0);

        // Off-screen coordinates
        do_reset();
        vga_ready = 1'b1;
        n0 = n_plots;
        push_one(160, 0, 1);
        push_one(0, 120, 2);
        repeat (4) tick();
`ifdef PIXEL_CLIP_EN
        check("clip_plots", n_plots - n0, 0);
        check("clip_count", count, 0);
        check("clip_overflow", overflow, 0);
`else
        check("noclip_plots", n_plots - n0, 2);
        check("noclip_x", vga_x, 0);
        check("noclip_y", vga_y, 120);
        check("noclip_colour", vga_colour, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Buffers single-pixel plot writes produced by the box/glyph drawing engines and drains them, one per cycle, into the VGA adapter's framebuffer write port under a ready handshake. It is the receiving end of the drawers' `x_out`/`y_out`/`colour`/plot-enable interface. It also provides a full-screen clear sweep, so the game FSM can wipe the board without a dedicated drawer.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of 2, at least 2.
- `SCREEN_W`, 160: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `plot_in`  in  1  write strobe; one pixel per cycle while high.
- `x_in`  in  8  pixel x.
- `y_in`  in  7  pixel y.
- `colour_in`  in  3  pixel colour {R,G,B}.
- `full`  out  1  combinational; high when `count == DEPTH`.
- `count`  out  $clog2(DEPTH)+1  registered occupancy.
- `overflow`  out  1  sticky; set by a push dropped while full.
- `clear_req`  in  1  one-cycle request to clear the screen.
- `clear_colour`  in  3  colour for the sweep, sampled with `clear_req`.
- `clear_busy`  out  1  high while a clear is pending or sweeping.
- `vga_ready`  in  1  sink can accept a pixel on the next edge.
- `vga_plot`  out  1  registered write enable to the VGA adapter.
- `vga_x`  out  8  registered pixel x.
- `vga_y`  out  7  registered pixel y.
- `vga_colour`  out  3  registered pixel colour.

## Operation
- Reset values:
  - `count`, `overflow`, `clear_busy`, `vga_plot`, `vga_x`, `vga_y`, `vga_colour` all 0.
  - Read and write pointers 0; FSM in `S_RUN`.
- FIFO push:
  - A push is accepted when `plot_in && !full`.
  - `full` is computed from the registered `count`. A push while full is dropped even if a pop happens in the same cycle, and it sets `overflow`.
  - `overflow` clears only on reset.
- FIFO pop:
  - Happens only in `S_RUN`, when `count != 0 && vga_ready`.
  - The head entry is loaded into `vga_x`/`vga_y`/`vga_colour` and `vga_plot` is set to 1.
  - In any cycle without a pop or sweep issue, `vga_plot` is 0 and the data registers hold their values.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- FSM states:
  - `S_RUN`: normal drain. A sampled `clear_req` latches `clear_colour`, sets `clear_busy` and moves to `S_WAIT`.
  - `S_WAIT`: keeps draining. Moves to `S_CLEAR` on the edge where `count == 0`, or where the final pop empties the FIFO with no push in that cycle.
  - `S_CLEAR`:
    - Each cycle with `vga_ready` high issues pixel (cx,cy) with the latched colour. cx runs 0..SCREEN_W-1 as the inner loop, cy runs 0..SCREEN_H-1 as the outer loop.
    - When `vga_ready` is low, nothing is issued and the counters hold.
    - After pixel (SCREEN_W-1, SCREEN_H-1) is issued, the FSM returns to `S_RUN`, `clear_busy` drops, and the counters are zeroed.
- Pushes stay accepted in `S_WAIT`/`S_CLEAR`. Pixels pushed during a sweep are drawn after it completes, so they overwrite the cleared screen.
- `clear_req` is ignored while `clear_busy` is high.
- A reset at any time, including mid-sweep, aborts all activity and discards FIFO contents.

## Timing
- Push to plot latency:
  - `plot_in` sampled at edge N into an empty FIFO with `vga_ready` high gives `vga_plot` high after edge N+1. Minimum latency is 2 cycles.
- Throughput: 1 pixel/cycle sustained with `vga_ready` held high, from either the FIFO or the sweep.
- The sink samples `vga_*` on the edge after `vga_plot` rises. `vga_plot` is never high for more than one cycle per pixel.
- Clear duration: `clear_req` at edge N with the FIFO empty and `vga_ready` always high:
  - `clear_busy` is high after edge N.
  - `S_CLEAR` is entered at N+1.
  - The first sweep `vga_plot` is after edge N+2.
  - The last sweep pixel is after edge N+2+SCREEN_W*SCREEN_H-1.
  - `clear_busy` is low after the following edge.

## Configuration
- `PIXEL_CLIP_EN`:
  - Defined: a push with `x_in >= SCREEN_W` or `y_in >= SCREEN_H` is discarded at the input. It is not stored, does not change `count`, and does not set `overflow`, even when full.
  - Undefined: all coordinates are stored and forwarded unchanged.

## Test plan
- Reset, then push (5,7,3'b001) with `vga_ready`=1 -> after 2 edges `vga_plot`=1, `vga_x`=5, `vga_y`=7, `vga_colour`=3'b001; `count` returns to 0.
- Hold `vga_ready`=0 and push 9 pixels with DEPTH=8 -> `count`=8, `full`=1, the 9th push is dropped, `overflow`=1. Then raise `vga_ready` -> exactly 8 plots, in order.
- FIFO full plus simultaneous push and pop -> push dropped, `count` goes to 7, `overflow`=1.
- `clear_req` with `clear_colour`=3'b000, FIFO holding 3 entries -> 3 FIFO plots first, then 19200 plots covering (0,0)..(159,119) in row-major order. `clear_busy` falls after the last one; a push made mid-sweep plots afterwards.
- Toggle `vga_ready` every cycle during a sweep -> no pixel skipped or repeated; 19200 plots total.
- With `PIXEL_CLIP_EN` defined, push (160,0) and (0,120) -> no plot, `count` stays 0. Undefined -> both are forwarded unchanged.
